alu_pipe: RTL and testbench

Parametrised, clocked successor to the combinational simple ALU. It keeps the same opcode set, operand shifter and S-gated NZCV flags, and adds four things:
- valid/ready handshakes on input and output
- a two-stage pipeline (shift stage, execute/output stage)
- an iterative multi-cycle multiplier
- ASR shift mode and an illegal-opcode error bit

It sits between the register-read and writeback stages of the CPU datapath.

---
 rtl/alu_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_alu_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: operand shifter in stage 1, execute/output register in stage 2.
// Uses valid/ready handshakes, an iterative shift-add multiplier and S-gated NZCV flags.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic [IMM_W-1:0] Immediate,
    input  logic [3:0]       Opcode,
    input  logic [2:0]       SR_Cont,
    input  logic [SHW-1:0]   SR_Bit,
    input  logic             S,
    output logic [WIDTH-1:0] Out,
    output logic             Out_Err,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [3:0]       Flags
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_MOVI = 4'b0110;
    localparam logic [3:0] OP_MOV  = 4'b0111;

    typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;

    // Stage 1 registers
    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg, s1_b_reg, s1_imm_reg;
    logic             s1_cs_reg, s1_s_reg;
    logic [3:0]       s1_op_reg;

    // Output stage registers
    logic [WIDTH-1:0] out_reg;
    logic             out_err_reg, out_valid_reg;
    logic [3:0]       flags_reg;

    // Multiplier
    mul_state_t       state_reg, state_next;
    logic [WIDTH-1:0] mcand_reg, mcand_next, mplier_reg, mplier_next, acc_reg, acc_next;
    logic [SHW-1:0]   cnt_reg, cnt_next;

    logic             in_fire, s2_load;
    logic [WIDTH-1:0] sh_b;
    logic             sh_cs;
    logic [SHW-1:0]   neg_amt;
    logic [WIDTH-1:0] ex_res;
    logic             ex_err, ex_c, ex_v;
    logic [WIDTH:0]   sum, diff;

    // A MUL in stage 1 may only retire once the multiplier has finished.
    assign s2_load  = s1_valid_reg && (!out_valid_reg || Out_Ready) &&
                      ((s1_op_reg != OP_MUL) || (state_reg == MUL_DONE));
    assign In_Ready = !s1_valid_reg || s2_load;
    assign in_fire  = In_Valid && In_Ready;
    assign neg_amt  = '0 - SR_Bit;

    always_comb begin
        sh_b  = In2;
        sh_cs = 1'b0;
        if (SR_Bit != '0) begin
            case (SR_Cont)
                3'b001: begin
                    sh_b  = In2 >> SR_Bit;
                    sh_cs = In2[SR_Bit - 1'b1];
                end
                3'b010: begin
                    sh_b  = In2 << SR_Bit;
                    sh_cs = In2[neg_amt];
                end
                3'b011: begin
                    sh_b  = (In2 >> SR_Bit) | (In2 << neg_amt);
                    sh_cs = sh_b[WIDTH-1];
                end
                3'b100: begin
                    sh_b  = $unsigned($signed(In2) >>> SR_Bit);
                    sh_cs = In2[SR_Bit - 1'b1];
                end
                default: begin
                    sh_b  = In2;
                    sh_cs = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_imm_reg   <= '0;
            s1_cs_reg    <= 1'b0;
            s1_s_reg     <= 1'b0;
            s1_op_reg    <= '0;
        end else if (in_fire) begin
            s1_valid_reg <= 1'b1;
            s1_a_reg     <= In1;
            s1_b_reg     <= sh_b;
            s1_imm_reg   <= WIDTH'(Immediate);
            s1_cs_reg    <= sh_cs;
            s1_s_reg     <= S;
            s1_op_reg    <= Opcode;
        end else if (s2_load) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // The multiplier starts straight from the input operands on accept.
    always_comb begin
        state_next  = state_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            MUL_BUSY: begin
                if (mplier_reg[0]) acc_next = acc_reg + mcand_reg;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + 1'b1;
                if (cnt_reg == SHW'(WIDTH - 1)) state_next = MUL_DONE;
            end
            MUL_DONE: if (s2_load) state_next = MUL_IDLE;
            default:  state_next = state_reg;
        endcase
        if (in_fire && (Opcode == OP_MUL)) begin
            state_next  = MUL_BUSY;
            mcand_next  = In1;
            mplier_next = sh_b;
            acc_next    = '0;
            cnt_next    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= MUL_IDLE;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign sum  = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
    assign diff = {1'b0, s1_a_reg} - {1'b0, s1_b_reg};

    always_comb begin
        ex_res = '0;
        ex_err = 1'b0;
        ex_c   = flags_reg[1];
        ex_v   = flags_reg[0];
        case (s1_op_reg)
            OP_ADD: begin
                ex_res = sum[WIDTH-1:0];
                ex_c   = sum[WIDTH];
                ex_v   = (s1_a_reg[WIDTH-1] == s1_b_reg[WIDTH-1]) &&
                         (sum[WIDTH-1] != s1_a_reg[WIDTH-1]);
            end
            OP_SUB: begin
                ex_res = diff[WIDTH-1:0];
                ex_c   = !diff[WIDTH];
                ex_v   = (s1_a_reg[WIDTH-1] != s1_b_reg[WIDTH-1]) &&
                         (diff[WIDTH-1] != s1_a_reg[WIDTH-1]);
            end
            OP_MUL:  ex_res = acc_reg;
            OP_OR:   begin ex_res = s1_a_reg | s1_b_reg; ex_c = s1_cs_reg; end
            OP_AND:  begin ex_res = s1_a_reg & s1_b_reg; ex_c = s1_cs_reg; end
            OP_XOR:  begin ex_res = s1_a_reg ^ s1_b_reg; ex_c = s1_cs_reg; end
            OP_MOVI: begin ex_res = s1_imm_reg;          ex_c = s1_cs_reg; end
            OP_MOV:  begin ex_res = s1_b_reg;            ex_c = s1_cs_reg; end
            default: ex_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg       <= '0;
            out_err_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            flags_reg     <= '0;
        end else if (s2_load) begin
            out_reg       <= ex_res;
            out_err_reg   <= ex_err;
            out_valid_reg <= 1'b1;
            if (s1_s_reg && !ex_err)
                flags_reg <= {ex_res[WIDTH-1], (ex_res == '0), ex_c, ex_v};
        end else if (Out_Ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign Out       = out_reg;
    assign Out_Err   = out_err_reg;
    assign Out_Valid = out_valid_reg;
    assign Flags     = flags_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: 32-bit instance for the main sequence, 16-bit instance for
// the narrow-width overflow case.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, s_bit, out_err, out_valid, out_ready;
    logic [31:0] in1, in2, out;
    logic [15:0] imm;
    logic [3:0]  opcode, flags;
    logic [2:0]  sr_cont;
    logic [4:0]  sr_bit;

    logic        w16_in_valid, w16_in_ready, w16_s, w16_out_err, w16_out_valid, w16_out_ready;
    logic [15:0] w16_in1, w16_in2, w16_imm, w16_out;
    logic [3:0]  w16_opcode, w16_flags;
    logic [2:0]  w16_sr_cont;
    logic [3:0]  w16_sr_bit;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(32), .IMM_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .In_Valid(in_valid), .In_Ready(in_ready),
        .In1(in1), .In2(in2), .Immediate(imm), .Opcode(opcode),
        .SR_Cont(sr_cont), .SR_Bit(sr_bit), .S(s_bit),
        .Out(out), .Out_Err(out_err), .Out_Valid(out_valid), .Out_Ready(out_ready),
        .Flags(flags)
    );

    alu_pipe #(.WIDTH(16), .IMM_W(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .In_Valid(w16_in_valid), .In_Ready(w16_in_ready),
        .In1(w16_in1), .In2(w16_in2), .Immediate(w16_imm), .Opcode(w16_opcode),
        .SR_Cont(w16_sr_cont), .SR_Bit(w16_sr_bit), .S(w16_s),
        .Out(w16_out), .Out_Err(w16_out_err), .Out_Valid(w16_out_valid),
        .Out_Ready(w16_out_ready), .Flags(w16_flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] src, input logic [4:0] amt, input logic s);
        opcode   = op;
        in1      = a;
        in2      = b;
        imm      = 16'h0;
        sr_cont  = src;
        sr_bit   = amt;
        s_bit    = s;
        in_valid = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] src, input logic [4:0] amt, input logic s);
        int n = 0;
        drive(op, a, b, src, amt, s);
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        $display("sent op=%b a=%h b=%h src=%b amt=%0d s=%b", op, a, b, src, amt, s);
    endtask

    task automatic wait_out(input string tag, input logic [31:0] exp, input logic exp_err);
        int n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check({tag, "_timeout"}, 32'd0, 32'd1);
        check(tag, out, exp);
        check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
        $display("result %s out=%h err=%b flags=%b", tag, out, out_err, flags);
        @(negedge clk);
    endtask

    logic [31:0] got[$];
    int          e, lo, first, idx, seen;
    logic        add_sent, accept;
    logic [31:0] xb [4];

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in1 = '0; in2 = '0; imm = '0; opcode = '0;
        sr_cont = '0; sr_bit = '0; s_bit = 1'b0; out_ready = 1'b1;
        w16_in_valid = 1'b0; w16_in1 = '0; w16_in2 = '0; w16_imm = '0; w16_opcode = '0;
        w16_sr_cont = '0; w16_sr_bit = '0; w16_s = 1'b0; w16_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", out, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD latency: presented after edge k, accepted at k+1, valid after k+2
        drive(4'b0000, 32'd15, 32'd20, 3'b000, 5'd0, 1'b1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        check("add_valid_k1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("add_valid_k2", {31'd0, out_valid}, 32'd1);
        check("add_out", out, 32'd35);
        check("add_flags", {28'd0, flags}, 32'h0);
        $display("result add out=%h flags=%b", out, flags);
        @(negedge clk);
        check("add_single_beat", {31'd0, out_valid}, 32'd0);

        send(4'b0001, 32'd10, 32'd30, 3'b000, 5'd0, 1'b1);
        wait_out("sub_neg", 32'hFFFF_FFEC, 1'b0);
        check("sub_neg_flags", {28'd0, flags}, 32'b1000);
        send(4'b0001, 32'd30, 32'd30, 3'b000, 5'd0, 1'b1);
        wait_out("sub_zero", 32'd0, 1'b0);
        check("sub_zero_flags", {28'd0, flags}, 32'b0110);

        send(4'b1010, 32'd1, 32'd2, 3'b000, 5'd0, 1'b1);
        wait_out("illegal", 32'd0, 1'b1);
        check("illegal_flags", {28'd0, flags}, 32'b0110);

        send(4'b0000, 32'hFFFF_FFFF, 32'd1, 3'b000, 5'd0, 1'b1);
        wait_out("add_carry", 32'd0, 1'b0);
        check("add_carry_flags", {28'd0, flags}, 32'b0110);

        send(4'b0000, 32'd30, 32'd10, 3'b011, 5'd4, 1'b1);
        wait_out("ror_add", 32'hA000_001E, 1'b0);
        check("ror_flags", {28'd0, flags}, 32'b1000);
        send(4'b0000, 32'd30, 32'd10, 3'b010, 5'd4, 1'b1);
        wait_out("lsl_add", 32'd190, 1'b0);
        check("lsl_flags", {28'd0, flags}, 32'b0000);
        send(4'b0100, 32'hFFFF_FFFF, 32'h8000_0000, 3'b100, 5'd4, 1'b1);
        wait_out("asr_and", 32'hF800_0000, 1'b0);
        check("asr_flags", {28'd0, flags}, 32'b1000);

        // MUL followed back-to-back by ADD
        drive(4'b0010, 32'd5, 32'd5, 3'b000, 5'd0, 1'b0);
        @(posedge clk);
        e = 1;
        @(negedge clk);
        drive(4'b0000, 32'd1, 32'd2, 3'b000, 5'd0, 1'b0);
        lo = 0; first = -1; add_sent = 1'b0;
        got.delete();
        while (e <= 40) begin
            #1;
            if (!in_ready) lo++;
            if (in_valid && in_ready) add_sent = 1'b1;
            if (out_valid) begin
                if (first < 0) first = e;
                got.push_back(out);
            end
            @(posedge clk);
            e++;
            @(negedge clk);
            if (add_sent) in_valid = 1'b0;
        end
        check("mul_in_ready_low_cycles", lo, 32'd32);
        check("mul_first_valid_edge", first, 32'd34);
        check("mul_result_count", got.size(), 32'd2);
        if (got.size() == 2) begin
            check("mul_out", got[0], 32'd25);
            check("mul_then_add", got[1], 32'd3);
            $display("result mul out=%h then add out=%h", got[0], got[1]);
        end

        // Back-pressure: four XORs with the consumer stalled
        xb[0] = 32'd1; xb[1] = 32'd2; xb[2] = 32'd3; xb[3] = 32'd4;
        out_ready = 1'b0;
        idx = 0;
        got.delete();
        for (int c = 0; c < 40 && (idx < 4 || got.size() < 4); c++) begin
            if (c == 6) begin
                check("bp_accepted", idx, 32'd2);
                check("bp_hold_out", out, 32'h0000_00F1);
                check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                out_ready = 1'b1;
            end
            if (idx < 4) drive(4'b0101, 32'h0000_00F0, xb[idx], 3'b000, 5'd0, 1'b0);
            else in_valid = 1'b0;
            #1;
            accept = in_valid && in_ready;
            if (out_valid && out_ready) got.push_back(out);
            @(posedge clk);
            if (accept) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_drain_count", got.size(), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            check($sformatf("bp_drain_%0d", i), got[i], 32'h0000_00F0 ^ xb[i]);
            $display("result bp_drain_%0d out=%h", i, got[i]);
        end

        // Reset in the middle of a multiply
        send(4'b0010, 32'd6, 32'd7, 3'b000, 5'd0, 1'b1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mul_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mul_flags", {28'd0, flags}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_mul_no_emit", seen, 32'd0);
        send(4'b0000, 32'd7, 32'd8, 3'b000, 5'd0, 1'b1);
        wait_out("post_rst_add", 32'd15, 1'b0);
        check("post_rst_flags", {28'd0, flags}, 32'b0000);

        // 16-bit build: signed overflow on 0x7FFF + 1
        w16_opcode = 4'b0000; w16_in1 = 16'h7FFF; w16_in2 = 16'h0001; w16_s = 1'b1;
        w16_in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        w16_in_valid = 1'b0;
        @(negedge clk);
        check("w16_valid", {31'd0, w16_out_valid}, 32'd1);
        check("w16_out", {16'd0, w16_out}, 32'h0000_8000);
        check("w16_flags", {28'd0, w16_flags}, 32'b1001);
        $display("result w16_add out=%h flags=%b", w16_out, w16_flags);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
